// File: rtl/semaforo_pkg.sv
// Shared types for the semaforo controller and its pedestrian-button conditioner.
package semaforo_pkg;

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] PRESS_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } deb_state_t;

  // Lamp-state encodings used by the semaforo controller.
  typedef enum logic [1:0] {
    VERDE    = 2'd0,
    AMARELO  = 2'd1,
    VERMELHO = 2'd2
  } lamp_t;

endpackage

// File: rtl/botao_condicionador_if.sv
// Button/request signals between the conditioner (slave) and its user (master).
interface botao_condicionador_if;
  import semaforo_pkg::*;

  logic             bt_raw;
  logic             ack;
  logic             bt;
  logic             pending;
  logic [CNT_W-1:0] press_count;

  modport master (output bt_raw, ack, input bt, pending, press_count);
  modport slave  (input bt_raw, ack, output bt, pending, press_count);
endinterface

// File: rtl/sincronizador.sv
// STAGES-deep synchroniser flop chain with asynchronous active-low reset.
module sincronizador #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/botao_condicionador.sv
// Pedestrian-button conditioner: sync, debounce FSM, sticky request, press counter.
// Optional post-ack lockout enabled by defining BT_LOCKOUT_EN.
module botao_condicionador
  import semaforo_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 8'd4
`ifdef BT_LOCKOUT_EN
  ,
  parameter logic [CNT_W-1:0] LOCKOUT_CYCLES  = 8'd3
`endif
) (
  input  logic                clk,
  input  logic                rst,
  botao_condicionador_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = DEBOUNCE_CYCLES - 8'd1;

  logic             s;
  deb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             press_evt;
  logic             locked;

  sincronizador #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.bt_raw),
    .q   (s)
  );

  always_comb begin
    press_evt = 1'b0;
    if (s) begin
      if (state == IDLE && DEBOUNCE_CYCLES == 8'd1)      press_evt = 1'b1;
      else if (state == CONFIRM_PRESS && cnt == LAST)    press_evt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 8'd1) begin
              state <= PRESSED;
            end else begin
              state       <= CONFIRM_PRESS;
              cnt         <= 8'd1;
              bus.pending <= 1'b1;
            end
          end
        end
        CONFIRM_PRESS: begin
          if (!s) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.pending <= 1'b0;
          end else if (cnt == LAST) begin
            state       <= PRESSED;
            bus.pending <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PRESSED: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 8'd1) begin
              state <= IDLE;
            end else begin
              state <= CONFIRM_RELEASE;
              cnt   <= 8'd1;
            end
          end
        end
        CONFIRM_RELEASE: begin
          if (s)                state <= PRESSED;
          else if (cnt == LAST) state <= IDLE;
          else                  cnt   <= cnt + 8'd1;
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          bus.pending <= 1'b0;
        end
      endcase
    end
  end

`ifdef BT_LOCKOUT_EN
  logic [CNT_W-1:0] lock_cnt;

  // The ack cycle itself is already inside the lockout window.
  assign locked = bus.ack || (lock_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 lock_cnt <= '0;
    else if (bus.ack)         lock_cnt <= LOCKOUT_CYCLES;
    else if (lock_cnt != '0)  lock_cnt <= lock_cnt - 8'd1;
  end
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.bt          <= 1'b0;
      bus.press_count <= '0;
    end else begin
      if (press_evt && !locked) bus.bt <= 1'b1;
      else if (bus.ack)         bus.bt <= 1'b0;
      if (press_evt && bus.press_count != PRESS_MAX)
        bus.press_count <= bus.press_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_botao_condicionador.sv
// Scoreboard bench for botao_condicionador: stimulus queues {press_count, bt} per output change.
module tb_botao_condicionador;
  import semaforo_pkg::*;

  typedef struct packed {
    logic [7:0] cnt;
    logic       bt;
  } exp_t;

  logic clk;
  logic rst;
  botao_condicionador_if bus ();

  botao_condicionador dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       q[$];
  int         tests;
  int         fails;
  logic [7:0] exp_cnt;
  logic       exp_bt;
  logic [7:0] prev_cnt;
  logic       prev_bt;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every change of {press_count, bt} must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      prev_cnt = '0;
      prev_bt  = 1'b0;
    end else if (bus.press_count != prev_cnt || bus.bt != prev_bt) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got cnt=%0d bt=%0d, nothing expected at %0t",
                 bus.press_count, bus.bt, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        tests++;
        if (e.cnt != bus.press_count || e.bt != bus.bt) begin
          fails++;
          $display("FAIL event: got cnt=%0d bt=%0d expected cnt=%0d bt=%0d at %0t",
                   bus.press_count, bus.bt, e.cnt, e.bt, $time);
        end
      end
      prev_cnt = bus.press_count;
      prev_bt  = bus.bt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'd255) ? 8'd255 : c + 8'd1;
  endfunction

  task automatic expect_state(input logic [7:0] c, input logic b);
    if (c != exp_cnt || b != exp_bt) q.push_back('{cnt: c, bt: b});
    exp_cnt = c;
    exp_bt  = b;
  endtask

  // Clean press: held 8 edges, ack optionally sampled at edge ack_edge, then released.
  task automatic press(input int ack_edge, input logic bt_after);
    logic bt_before;
    bt_before = exp_bt;
    expect_state(sat_inc(exp_cnt), bt_after);
    bus.bt_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      bus.ack = (i == ack_edge - 1);
      if (i >= 2 && i <= 6) check("pending", int'(bus.pending), int'(i >= 3 && i <= 5));
      if (i == 5) check("bt_before_confirm", int'(bus.bt), int'(bt_before));
      if (i == 6) check("bt_at_confirm", int'(bus.bt), int'(bt_after));
    end
    bus.bt_raw = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
  endtask

  task automatic do_ack();
    expect_state(exp_cnt, 1'b0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("bt_after_ack", int'(bus.bt), 0);
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_bt", int'(bus.bt), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_count", int'(bus.press_count), 0);
    check("rst_queue_drained", q.size(), 0);
    q.delete();
    exp_cnt = '0;
    exp_bt  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    exp_cnt    = '0;
    exp_bt     = 1'b0;
    rst        = 1'b1;
    bus.bt_raw = 1'b0;
    bus.ack    = 1'b0;
    tick();

    // 1: reset, then a long hold gives exactly one event at edge 6
    apply_reset();
    expect_state(8'd1, 1'b1);
    bus.bt_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("t1_pending", int'(bus.pending), int'(i >= 3 && i <= 5));
      check("t1_bt", int'(bus.bt), int'(i >= 6));
    end
    check("t1_count", int'(bus.press_count), 1);
    bus.bt_raw = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    do_ack();

    // 2: 3-cycle glitch is rejected
    bus.bt_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) bus.bt_raw = 1'b0;
      check("t2_pending", int'(bus.pending), int'(i >= 3 && i <= 5));
    end
    check("t2_bt", int'(bus.bt), 0);
    check("t2_count", int'(bus.press_count), 1);

    // 3: ack clears; press coinciding with ack keeps the request
    press(0, 1'b1);
    do_ack();
    press(0, 1'b1);
`ifdef BT_LOCKOUT_EN
    press(6, 1'b0);
`else
    press(6, 1'b1);
`endif
    do_ack();
    do_ack();
    check("t3_count", int'(bus.press_count), 4);

    // 4: reset in CONFIRM_PRESS with cnt=2, button still held afterwards
    bus.bt_raw = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    check("t4_pending_pre", int'(bus.pending), 1);
    apply_reset();
    expect_state(8'd1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check("t4_bt_edge5", int'(bus.bt), 0);
      if (i == 6) check("t4_bt_edge6", int'(bus.bt), 1);
    end
    bus.bt_raw = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    do_ack();

`ifdef BT_LOCKOUT_EN
    // 6: press confirmed inside the lockout only counts
    press(5, 1'b0);
    check("t6_count_locked", int'(bus.press_count), 2);
    press(0, 1'b1);
    check("t6_count_free", int'(bus.press_count), 3);
    do_ack();
`endif

    // 5: saturation at 255
    while (exp_cnt != 8'd255) begin
      press(0, 1'b1);
      do_ack();
    end
    check("t5_count_255", int'(bus.press_count), 255);
    for (int i = 0; i < 5; i++) begin
      press(0, 1'b1);
      do_ack();
    end
    check("t5_count_sat", int'(bus.press_count), 255);

    tick();
    tick();
    check("final_queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/botao_condicionador.md
Name: botao_condicionador

Overview:
Pedestrian-button conditioner that sits directly upstream of the semaforo controller and drives its bt input.
- Synchronises the raw, asynchronous push-button and debounces it with a 4-state FSM.
- Turns each confirmed press into a sticky request that is held until the controller acknowledges it.
- Keeps a saturating press counter for diagnostics.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on bt_raw (legal range 2..4)
DEBOUNCE_CYCLES, 8'd4, consecutive equal synchronised samples needed to confirm a press or a release (legal range 1..255)
LOCKOUT_CYCLES, 8'd3, post-ack lockout length in cycles; used only when BT_LOCKOUT_EN is defined (legal range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
bt_raw  input  1  raw button level, asynchronous to clk
ack  input  1  controller acknowledge; one-cycle pulse when the controller has served the request
bt  output  1  registered, sticky pedestrian request; connects to semaforo bt
pending  output  1  high while a press is being confirmed (FSM in CONFIRM_PRESS)
press_count  output  8  number of confirmed presses, saturating

Behaviour:
- Reset: clk and one asynchronous active-low reset; rst=0 immediately forces the following, regardless of clk:
  - bt=0, pending=0, press_count=0
  - all synchroniser flops=0, FSM=IDLE, debounce counter=0
- Synchroniser: an SYNC_STAGES-deep flop chain on bt_raw; its last stage is s. Only the FSM reads s.
- FSM states: IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE. The 8-bit debounce counter cnt counts consecutive qualifying samples.
  - IDLE:
    - s=1 and DEBOUNCE_CYCLES=1 -> PRESSED, press event.
    - s=1 otherwise -> CONFIRM_PRESS, cnt=1.
    - s=0 -> stay.
  - CONFIRM_PRESS:
    - s=0 -> IDLE, cnt=0, no event.
    - s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, press event.
    - s=1 otherwise -> cnt+1.
  - PRESSED:
    - s=0 and DEBOUNCE_CYCLES=1 -> IDLE.
    - s=0 otherwise -> CONFIRM_RELEASE, cnt=1.
  - CONFIRM_RELEASE:
    - s=1 -> PRESSED, no new event.
    - s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - s=0 otherwise -> cnt+1.
- Latency: bt_raw first sampled high at edge 1 -> press event and bt=1 at edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults that is edge 6.
- pending is a registered decode of FSM==CONFIRM_PRESS.
- Request latch (bt):
  - Set on a press event; cleared on ack.
  - press event and ack in the same cycle -> bt stays 1; the new press is not lost.
  - ack while bt=0 -> ignored, no error.
  - Repeated presses while bt=1 -> bt stays 1; press_count still increments.
- press_count: +1 per press event, saturates at 8'd255 and never wraps.
- Long hold: stays in PRESSED with exactly one event per press, however long the button is held.
- Reset mid-operation (any state, any cnt): everything returns to reset values; a button still held after reset release is debounced again as a fresh press.

Optional Feature:
BT_LOCKOUT_EN
- Defined:
  - ack starts a lockout counter of LOCKOUT_CYCLES cycles.
  - Press events confirmed during the lockout do not set bt but still increment press_count.
  - Lockout overrides the simultaneous press+ack rule: bt clears.
  - Reset clears the lockout.
- Not defined: no lockout logic or registers; behaviour exactly as specified above.

Decomposition:
- Shared package semaforo_pkg holds:
  - the debounce FSM state typedef (2-bit: IDLE=0, CONFIRM_PRESS=1, PRESSED=2, CONFIRM_RELEASE=3);
  - constant CNT_W=8 and constant PRESS_MAX=8'd255;
  - the controller's lamp-state encodings already shared with semaforo.
- One sub-module, sincronizador: parameterised SYNC_STAGES flop chain with asynchronous active-low reset. The FSM, request latch and counters stay in botao_condicionador.

Test Plan:
1. Defaults; rst=0 for 2 cycles, then bt_raw=1 for 12 cycles -> bt=1 and press_count=1 at edge 6 after bt_raw rises; pending high on edges 3-5.
2. bt_raw glitch of 3 cycles (less than DEBOUNCE_CYCLES=4) -> bt stays 0, press_count=0, FSM returns to IDLE.
3. Press confirmed, bt=1; ack pulse for 1 cycle -> bt=0 at the next edge. Second press confirmed in the same cycle as an ack -> bt stays 1, press_count=2.
4. Assert rst=0 mid-CONFIRM_PRESS (cnt=2) -> all outputs 0 immediately without a clk edge; release rst with bt_raw held -> bt rises SYNC_STAGES+DEBOUNCE_CYCLES edges later.
5. 260 clean presses, each with release -> press_count reads 255 after press 255 and stays 255; bt behaves normally throughout.
6. BT_LOCKOUT_EN defined, LOCKOUT_CYCLES=3: ack, then a press confirmed inside the lockout -> bt stays 0, press_count increments; a press confirmed after the lockout -> bt=1.
